// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: FETCH/WAIT/ISSUE loop over a 1-cycle-latency ROM.
// Optional HALT state on opcode 4'hF when FETCH_HALT_EN is defined.
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic [15:0] rom_data,
  output logic [7:0]  pc,
  output logic [15:0] instr_out,
  output logic [3:0]  opcode,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
`ifdef FETCH_HALT_EN
  localparam logic [2:0] S_HALT  = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] cnt_q, cnt_d;

  logic        is_jump;
  logic [7:0]  pc_step;
  logic [7:0]  pc_next;
  logic [15:0] cnt_inc;

  assign is_jump = (instr_q[15:12] == 4'h9);
  assign pc_step = is_jump ? instr_q[7:0] : 8'd1;
  // 8-bit add wraps silently, which covers both +1 and jump offsets
  assign pc_next = pc_q + pc_step;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef FETCH_HALT_EN
  logic is_halt;
  assign is_halt = (instr_q[15:12] == 4'hF);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 8'd0;
          cnt_d   = 16'd0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        instr_d = rom_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!stall) begin
`ifdef FETCH_HALT_EN
          if (is_halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            pc_d    = pc_next;
            cnt_d   = cnt_inc;
          end
`else
          state_d = S_FETCH;
          pc_d    = pc_next;
          cnt_d   = cnt_inc;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = 8'd0;
          cnt_d   = 16'd0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= 8'd0;
      instr_q <= 16'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign instr_out   = instr_q;
  assign opcode      = instr_q[15:12];
  assign fetch_count = cnt_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign busy        = (state_q == S_FETCH) ||
                       (state_q == S_WAIT) ||
                       (state_q == S_ISSUE);
`ifdef FETCH_HALT_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have exactly one parameter: none; all widths are fixed (8-bit PC, 16-bit instruction, 4-bit opcode).
REQ-002 The block SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 The block SHALL provide port start  input  1  begin fetching from address 0 when idle or halted.
REQ-005 The block SHALL provide port stall  input  1  downstream not ready; holds the presented instruction.
REQ-006 The block SHALL provide port rom_data  input  16  instruction word from the instruction ROM, registered there with one-cycle read latency.
REQ-007 The block SHALL provide port pc  output  8  ROM read address.
REQ-008 The block SHALL provide port instr_out  output  16  captured instruction.
REQ-009 The block SHALL provide port opcode  output  4  instr_out[15:12].
REQ-010 The block SHALL provide port instr_valid  output  1  instr_out valid; a transfer occurs on any cycle with instr_valid=1 and stall=0.
REQ-011 The block SHALL provide port busy  output  1  high in FETCH, WAIT and ISSUE.
REQ-012 The block SHALL provide port halted  output  1  high in HALT.
REQ-013 The block SHALL provide port fetch_count  output  16  number of completed transfers since the last start, saturating at 16'hFFFF.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, WAIT, ISSUE and HALT.
REQ-015 IDLE: pc=0, busy=0; start=1 SHALL move to FETCH and clear fetch_count.
REQ-016 FETCH: pc SHALL be held stable; next state WAIT.
REQ-017 WAIT: at the end of this cycle rom_data SHALL be captured into instr_out; next state ISSUE.
REQ-018 ISSUE: instr_valid SHALL be 1; while stall=1 the state, pc and instr_out SHALL hold.
REQ-019 ISSUE with stall=0: fetch_count SHALL increment (saturating), pc SHALL update and the FSM SHALL return to FETCH.
REQ-020 Next pc SHALL be pc + instr_out[7:0] (mod 256) when opcode = 4'h9, and pc + 1 (mod 256) otherwise.
REQ-021 pc wrap SHALL be silent: 8'hFF+1 = 8'h00; a jump offset of 0 SHALL self-loop on the same address.
REQ-022 Fetch latency SHALL be 3 cycles from pc change to the first instr_valid cycle; back-to-back throughput SHALL be 1 instruction per 3 cycles when stall=0.
REQ-023 start SHALL be ignored in FETCH, WAIT and ISSUE.
REQ-024 instr_valid SHALL be 0 in every state except ISSUE.

Reset
REQ-025 rst=0 SHALL, asynchronously and in any state including mid-ISSUE, force IDLE and set pc=0, instr_out=0, instr_valid=0, busy=0, halted=0 and fetch_count=0.
REQ-026 Leaving reset SHALL NOT start fetching; an explicit start is required.

Configuration
REQ-027 With macro FETCH_HALT_EN defined, a transfer of opcode 4'hF SHALL move the FSM to HALT instead of FETCH, leave pc unchanged and hold fetch_count.
REQ-028 In HALT: halted=1, busy=0, instr_valid=0; start=1 SHALL set pc=0, clear fetch_count and go to FETCH.
REQ-029 Without FETCH_HALT_EN, opcode 4'hF SHALL be sequenced as a normal instruction (pc+1), the HALT state SHALL be absent and halted SHALL be tied to 0.

Verification
REQ-030 Reset then start with ROM[0..2] non-jump: pc sequence 0,1,2; instr_valid on cycles 3, 6 and 9 after start; fetch_count=3.
REQ-031 ROM[2]=16'h9005: the transfer at pc=2 causes the next fetch at pc=7.
REQ-032 pc=8'hFF with a non-jump instruction -> next pc=8'h00; pc=8'hF0 with offset 8'h20 -> next pc=8'h10.
REQ-033 stall held high for 5 cycles in ISSUE -> instr_out, pc and fetch_count are unchanged and instr_valid stays 1; the transfer completes on the first stall=0 cycle.
REQ-034 rst pulsed low during ISSUE at pc=5 -> immediate IDLE with all outputs 0; no fetch occurs until start.
REQ-035 With FETCH_HALT_EN, ROM[3]=16'hF000 -> halted=1 with pc=3; start -> pc=0 and fetching resumes; without the macro, pc advances to 4.
